pwm_duty_sequencer: RTL and testbench

Upstream command stage for the servo PWM generator in the slave design. It accepts duty-level commands (0..MAX_LEVEL) over a valid/ready byte interface and produces the frame timebase. It ramps its registered duty-level output toward each commanded target one step at a time, changing it only on PWM frame boundaries, so the downstream PWM stage never sees a mid-frame or abrupt duty change.

---
 rtl/pwm_duty_sequencer_if.sv | 10 +
 rtl/pwm_duty_sequencer.sv | 109 ++++++++++
 tb/tb_pwm_duty_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_sequencer_if.sv
// Command byte handshake into the PWM duty sequencer.
// The master drives valid/data and the sequencer drives ready.
interface pwm_duty_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;

    modport master (output cmd_valid, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Frame timebase plus a duty-level ramp that only moves on frame boundaries.
// Optional PWM_SEQ_RETARGET_EN lets new commands retarget a ramp in progress.
//
// state | meaning
// IDLE  | duty_level == target, ready for a command
// RAMP  | stepping duty_level toward target every STEP_FRAMES frames
module pwm_duty_sequencer #(
    parameter int FRAME_CYCLES = 1000000,
    parameter int STEP_FRAMES  = 5,
    parameter int MAX_LEVEL    = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    pwm_duty_sequencer_if.slave    cmd,
    output logic [3:0]             duty_level,
    output logic                   frame_start,
    output logic                   busy,
    output logic                   cmd_err
);
    localparam int FC_W = $clog2(FRAME_CYCLES);
    localparam int SC_W = $clog2(STEP_FRAMES) + 1;

    typedef enum logic {IDLE, RAMP} state_t;

    state_t          state;
    logic [FC_W-1:0] frame_cnt;
    logic [SC_W-1:0] step_cnt;
    logic [3:0]      target;
    logic            xfer;
    logic            over;
    logic [3:0]      lvl;
    logic [3:0]      next_duty;
    logic            step_due;

    assign xfer      = cmd.cmd_valid && cmd.cmd_ready;
    assign over      = cmd.cmd_data > 8'(MAX_LEVEL);
    assign lvl       = cmd.cmd_data[3:0];
    assign next_duty = (target > duty_level) ? duty_level + 4'd1 : duty_level - 4'd1;
    assign step_due  = frame_start && (step_cnt == SC_W'(STEP_FRAMES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (frame_cnt == FC_W'(FRAME_CYCLES - 1));
            if (frame_cnt == FC_W'(FRAME_CYCLES - 1))
                frame_cnt <= '0;
            else
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            step_cnt      <= '0;
            target        <= '0;
            duty_level    <= '0;
            busy          <= 1'b0;
            cmd.cmd_ready <= 1'b0;
            cmd_err       <= 1'b0;
        end else begin
            cmd_err <= xfer && over;
            case (state)
                IDLE: begin
                    cmd.cmd_ready <= 1'b1;
                    busy          <= 1'b0;
                    if (xfer && !over && lvl != duty_level) begin
                        target   <= lvl;
                        step_cnt <= '0;
                        state    <= RAMP;
                        busy     <= 1'b1;
`ifdef PWM_SEQ_RETARGET_EN
                        cmd.cmd_ready <= 1'b1;
`else
                        cmd.cmd_ready <= 1'b0;
`endif
                    end
                end
                RAMP: begin
`ifdef PWM_SEQ_RETARGET_EN
                    // A legal retarget takes priority over a step landing this edge.
                    if (xfer && !over) begin
                        target   <= lvl;
                        step_cnt <= '0;
                        if (lvl == duty_level) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else
`endif
                    if (step_due) begin
                        duty_level <= next_duty;
                        step_cnt   <= '0;
                        if (next_duty == target) begin
                            state         <= IDLE;
                            busy          <= 1'b0;
                            cmd.cmd_ready <= 1'b1;
                        end
                    end else if (frame_start) begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Scoreboard bench for pwm_duty_sequencer with FRAME_CYCLES=10, STEP_FRAMES=2, MAX_LEVEL=10.
module tb_pwm_duty_sequencer;
    localparam int FC   = 10;
    localparam int SF   = 2;
    localparam int MAXL = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] duty_level;
    logic       frame_start, busy, cmd_err;

    pwm_duty_sequencer_if bus ();

    pwm_duty_sequencer #(.FRAME_CYCLES(FC), .STEP_FRAMES(SF), .MAX_LEVEL(MAXL)) dut (
        .clk(clk), .rst(rst), .cmd(bus.slave), .duty_level(duty_level),
        .frame_start(frame_start), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct { int level; int frame; bit last; } exp_t;
    exp_t exp_q[$];
    int   err_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fcount = 0;
    int prev_duty = 0;
    bit err_prev = 0;
    int model_duty = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            fcount    = 0;
            prev_duty = int'(duty_level);
            err_prev  = 0;
        end else begin
            if (frame_start) fcount++;
            if (cmd_err) begin
                if (err_prev) chk("cmd_err_width", 2, 1);
                if (err_q.size() == 0) chk("unexpected_cmd_err", int'(cmd_err), 0);
                else chk("cmd_err_cycle", cyc, err_q.pop_front());
            end
            err_prev = cmd_err;
            if (int'(duty_level) != prev_duty) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_duty", int'(duty_level), prev_duty);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("step_level", int'(duty_level), e.level);
                    chk("step_frame", fcount, e.frame);
                    chk("step_busy", int'(busy), e.last ? 0 : 1);
                    if (e.last) chk("step_ready_final", int'(bus.cmd_ready), 1);
                end
            end
            prev_duty = int'(duty_level);
        end
    end

    task automatic push_ramp(input int from, input int to, input int f0);
        int k = 1;
        int d = from;
        while (d != to) begin
            exp_t e;
            d = (to > d) ? d + 1 : d - 1;
            e.level = d;
            e.frame = f0 + k * SF;
            e.last  = (d == to);
            exp_q.push_back(e);
            k++;
        end
    endtask

    task automatic issue(input int d);
        int  f0 = 0;
        int  c0 = 0;
        bit  done = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'(d);
        for (int n = 0; n < 2000 && !done; n++) begin
            if (bus.cmd_ready) begin
                @(posedge clk);
                #1;
                f0 = fcount;
                c0 = cyc;
                bus.cmd_valid = 1'b0;
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        bus.cmd_valid = 1'b0;
        if (!done) chk("xfer_timeout", 0, 1);
        else if (d > MAXL) err_q.push_back(c0);
        else if (d != model_duty) begin
            push_ramp(model_duty, d, f0);
            model_duty = d;
            chk("busy_after_xfer", int'(busy), 1);
`ifdef PWM_SEQ_RETARGET_EN
            chk("ready_after_xfer", int'(bus.cmd_ready), 1);
`else
            chk("ready_after_xfer", int'(bus.cmd_ready), 0);
`endif
        end else begin
            chk("same_level_busy", int'(busy), 0);
        end
    endtask

    task automatic wait_duty(input int v);
        int n = 0;
        while (int'(duty_level) != v && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_duty_reached", int'(duty_level), v);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_busy", int'(busy), 0);
        chk("wait_idle_queue", exp_q.size(), 0);
    endtask

    task automatic release_and_check_frames();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_before_first_edge", int'(bus.cmd_ready), 0);
        for (int i = 1; i <= 21; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("frame_start_c%0d", i), int'(frame_start), (i == 10 || i == 20) ? 1 : 0);
            if (i == 1) chk("ready_after_release", int'(bus.cmd_ready), 1);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'd0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_duty", int'(duty_level), 0);
        chk("rst_ready", int'(bus.cmd_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_cmd_err", int'(cmd_err), 0);
        release_and_check_frames();

        issue(4);
        wait_idle();
        chk("ramp_up_final", int'(duty_level), 4);
        chk("ramp_up_ready", int'(bus.cmd_ready), 1);

        issue(11);
        repeat (3) @(negedge clk);
        chk("err_duty_kept", int'(duty_level), 4);
        chk("err_busy_kept", int'(busy), 0);
        chk("err_ready_kept", int'(bus.cmd_ready), 1);
        issue(4);
        repeat (3) @(negedge clk);
        chk("same_level_idle", int'(busy), 0);

        issue(0);
        wait_duty(2);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midramp_rst_duty", int'(duty_level), 0);
        chk("midramp_rst_busy", int'(busy), 0);
        chk("midramp_rst_ready", int'(bus.cmd_ready), 0);
        exp_q.delete();
        model_duty = 0;
        repeat (2) @(negedge clk);
        release_and_check_frames();

        issue(10);
        wait_duty(3);
`ifdef PWM_SEQ_RETARGET_EN
        chk("retarget_ready_in_ramp", int'(bus.cmd_ready), 1);
        exp_q.delete();
        model_duty = 3;
`else
        chk("ramp_ready_low", int'(bus.cmd_ready), 0);
        chk("ramp_busy_high", int'(busy), 1);
`endif
        issue(2);
        wait_idle();
        chk("final_duty", int'(duty_level), 2);
        repeat (5) @(negedge clk);
        chk("err_q_drained", err_q.size(), 0);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
